psram_responder: RTL and testbench

Synthesizable single-clock responder for the controller-side DDR-split PSRAM interface; it stands in for the `psram_phy` and the PSRAM device so `psram_controller` and `psram_rw` can be simulated and bench-tested without pads. It decodes command and address beats from `psram_ce` and `dq_out_hi/lo`, honours the configured latency, and stores or returns burst data in an internal word memory. It also answers mode-register accesses and drives `dm_in_hi/lo` as a read strobe.

---
 rtl/psram_pkg.sv | 30 +++
 rtl/psram_resp_mem.sv | 78 +++++++
 rtl/psram_responder.sv | 215 +++++++++++++++++++++
 tb/tb_psram_responder.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psram_pkg.sv
// Shared definitions for the PSRAM responder: opcodes, FSM encoding and
// the mode-register count.
package psram_pkg;

  localparam logic [7:0] CMD_SYNC_WR = 8'h20;
  localparam logic [7:0] CMD_SYNC_RD = 8'hA0;
  localparam logic [7:0] CMD_REG_WR  = 8'hC0;
  localparam logic [7:0] CMD_REG_RD  = 8'h40;

  localparam int MR_NUM = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR_H = 3'd1,
    ADDR_L = 3'd2,
    LAT    = 3'd3,
    WDATA  = 3'd4,
    RDATA  = 3'd5,
    REGW   = 3'd6,
    IGNORE = 3'd7
  } state_t;

  function automatic logic cmd_known(input logic [7:0] cmd);
    case (cmd)
      CMD_SYNC_WR, CMD_SYNC_RD, CMD_REG_WR, CMD_REG_RD: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/psram_resp_mem.sv
// Two-word-per-cycle RAM with byte enables; words live at an even address and
// its odd neighbour. The read register doubles as the responder's DQ output.
module psram_resp_mem
  import psram_pkg::*;
#(
  parameter int BIT_WIDTH = 16,
  parameter int MEM_AW    = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [MEM_AW-1:0]    wr_addr,
  input  logic [BIT_WIDTH-1:0] wr_hi,
  input  logic [BIT_WIDTH-1:0] wr_lo,
  input  logic [1:0]           be_hi,
  input  logic [1:0]           be_lo,
  input  logic                 rd_en,
  input  logic [MEM_AW-1:0]    rd_addr,
  input  logic                 ld_en,
  input  logic [BIT_WIDTH-1:0] ld_word,
  output logic [BIT_WIDTH-1:0] q_hi,
  output logic [BIT_WIDTH-1:0] q_lo
);

  localparam int BYTE_W = 8;

  logic [BIT_WIDTH-1:0] mem_r [0:(2**MEM_AW)-1];
  logic [BIT_WIDTH-1:0] q_hi_r;
  logic [BIT_WIDTH-1:0] q_lo_r;
  logic [MEM_AW-1:0]    wr_addr_odd_s;
  logic [MEM_AW-1:0]    rd_addr_odd_s;
  logic [BIT_WIDTH-1:0] mask_hi_s;
  logic [BIT_WIDTH-1:0] mask_lo_s;

  // Byte 0 is bits [7:0]; everything above belongs to byte 1.
  function automatic logic [BIT_WIDTH-1:0] bit_mask(input logic [1:0] be);
    logic [BIT_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < BIT_WIDTH; i++) begin
      m[i] = (i < BYTE_W) ? be[0] : be[1];
    end
    return m;
  endfunction

  assign wr_addr_odd_s = {wr_addr[MEM_AW-1:1], 1'b1};
  assign rd_addr_odd_s = {rd_addr[MEM_AW-1:1], 1'b1};
  assign mask_hi_s     = bit_mask(be_hi);
  assign mask_lo_s     = bit_mask(be_lo);

  // Storage write, deliberately unreset so contents survive ram_rst.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr]       <= (mem_r[wr_addr] & ~mask_hi_s) | (wr_hi & mask_hi_s);
      mem_r[wr_addr_odd_s] <= (mem_r[wr_addr_odd_s] & ~mask_lo_s) | (wr_lo & mask_lo_s);
    end
  end

  // Registered read port; idles at zero unless reading or loading a register word.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_hi_r <= '0;
      q_lo_r <= '0;
    end else if (rd_en) begin
      q_hi_r <= mem_r[rd_addr];
      q_lo_r <= mem_r[rd_addr_odd_s];
    end else if (ld_en) begin
      q_hi_r <= ld_word;
      q_lo_r <= ld_word;
    end else begin
      q_hi_r <= '0;
      q_lo_r <= '0;
    end
  end

  assign q_hi = q_hi_r;
  assign q_lo = q_lo_r;

endmodule

// File: rtl/psram_responder.sv
// Stand-in for psram_phy plus the PSRAM device on the controller-side DDR-split bus.
// Define PSRAM_RESP_CHECK_EN to build the sticky protocol checker behind err_protocol.
module psram_responder
  import psram_pkg::*;
#(
  parameter int    LATENCY   = 3,
  parameter int    BIT_WIDTH = 16,
  parameter int    BURST_LEN = 32,
  parameter string WARP_MODE = "Wrap",
  parameter int    MEM_AW    = 10
) (
  input  logic                 ram_clk,
  input  logic                 ram_rst,
  input  logic                 psram_ce,
  input  logic                 dq_en,
  input  logic [BIT_WIDTH-1:0] dq_out_hi,
  input  logic [BIT_WIDTH-1:0] dq_out_lo,
  input  logic                 dm_en,
  input  logic [1:0]           dm_out_hi,
  input  logic [1:0]           dm_out_lo,
  output logic [BIT_WIDTH-1:0] dq_in_hi,
  output logic [BIT_WIDTH-1:0] dq_in_lo,
  output logic [1:0]           dm_in_hi,
  output logic [1:0]           dm_in_lo,
  output logic                 resp_busy,
  output logic                 err_protocol
);

  localparam int                CW       = $clog2(LATENCY + 1);
  localparam bit                WRAP     = (WARP_MODE == "Wrap");
  localparam logic [MEM_AW-1:0] LOW_MASK = MEM_AW'(BURST_LEN - 1);

  state_t            state_r, state_s;
  logic [CW-1:0]     cnt_r;
  logic [7:0]        cmd_r;
  logic [15:0]       addr_hi_r;
  logic [MEM_AW-1:0] ptr_r;
  logic [2:0]        mr_idx_r;
  logic [7:0]        mr_r [0:MR_NUM-1];
  logic [1:0]        dm_hi_r;
  logic [1:0]        dm_lo_r;
  logic              busy_r;
  logic [31:0]       addr_full_s;
  logic              hdr_s, addr_h_s, addr_l_s, lat_dec_s, wr_en_s, mr_wr_s;
  logic              rd_sel_s, mem_rd_s, mr_ld_s;
  logic              unused_s;

  // Wrap mode holds the upper pointer bits and rolls the low bits inside the burst block.
  function automatic logic [MEM_AW-1:0] ptr_step(input logic [MEM_AW-1:0] p);
    logic [MEM_AW-1:0] lin;
    lin = p + MEM_AW'(2'd2);
    if (WRAP) return (p & ~LOW_MASK) | (lin & LOW_MASK);
    else return lin;
  endfunction

  assign addr_full_s = {addr_hi_r, dq_out_hi[7:0], dq_out_lo[7:0]};

  // FSM state register.
  always_ff @(posedge ram_clk) begin
    if (ram_rst) state_r <= IDLE;
    else state_r <= state_s;
  end

  // FSM next state; a high CE always returns to IDLE.
  always_comb begin
    state_s = state_r;
    if (psram_ce) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_s = cmd_known(dq_out_hi[7:0]) ? ADDR_H : IGNORE;
        ADDR_H:  state_s = ADDR_L;
        ADDR_L:  state_s = (cmd_r == CMD_REG_WR) ? REGW : LAT;
        LAT: begin
          if (cnt_r == '0) state_s = (cmd_r == CMD_SYNC_WR) ? WDATA : RDATA;
          else state_s = LAT;
        end
        WDATA:   state_s = WDATA;
        RDATA:   state_s = (cmd_r == CMD_SYNC_RD) ? RDATA : IGNORE;
        REGW:    state_s = IGNORE;
        IGNORE:  state_s = IGNORE;
        default: state_s = IDLE;
      endcase
    end
  end

  // FSM outputs: per-state strobes for the datapath and read-port controls.
  always_comb begin
    hdr_s     = 1'b0;
    addr_h_s  = 1'b0;
    addr_l_s  = 1'b0;
    lat_dec_s = 1'b0;
    wr_en_s   = 1'b0;
    mr_wr_s   = 1'b0;
    if (!psram_ce) begin
      case (state_r)
        IDLE:    hdr_s     = 1'b1;
        ADDR_H:  addr_h_s  = 1'b1;
        ADDR_L:  addr_l_s  = 1'b1;
        LAT:     lat_dec_s = (cnt_r != '0);
        WDATA:   wr_en_s   = 1'b1;
        REGW:    mr_wr_s   = 1'b1;
        default: hdr_s     = 1'b0;
      endcase
    end else begin
      hdr_s = 1'b0;
    end
    // The read register loads on the edge that enters RDATA, so look at the next state.
    rd_sel_s = (state_s == RDATA);
    mem_rd_s = rd_sel_s && (cmd_r == CMD_SYNC_RD);
    mr_ld_s  = rd_sel_s && (cmd_r != CMD_SYNC_RD);
  end

  // Command, address, pointer and latency-counter tracking.
  always_ff @(posedge ram_clk) begin
    if (ram_rst) begin
      cmd_r     <= 8'h00;
      addr_hi_r <= 16'h0000;
      ptr_r     <= '0;
      mr_idx_r  <= 3'd0;
      cnt_r     <= '0;
    end else begin
      if (hdr_s) cmd_r <= dq_out_hi[7:0];
      if (addr_h_s) addr_hi_r <= {dq_out_hi[7:0], dq_out_lo[7:0]};
      if (addr_l_s) begin
        ptr_r    <= {addr_full_s[MEM_AW-1:1], 1'b0};
        mr_idx_r <= addr_full_s[2:0];
      end else if (wr_en_s || mem_rd_s) begin
        ptr_r <= ptr_step(ptr_r);
      end
      if (addr_l_s) cnt_r <= CW'(LATENCY - 1);
      else if (lat_dec_s) cnt_r <= cnt_r - CW'(1'b1);
    end
  end

  // Mode registers.
  always_ff @(posedge ram_clk) begin
    if (ram_rst) begin
      for (int i = 0; i < MR_NUM; i++) mr_r[i] <= 8'h00;
    end else if (mr_wr_s) begin
      mr_r[mr_idx_r] <= dq_out_hi[7:0];
    end
  end

  // Registered strobe and busy flag.
  always_ff @(posedge ram_clk) begin
    if (ram_rst) begin
      dm_hi_r <= 2'b00;
      dm_lo_r <= 2'b00;
      busy_r  <= 1'b0;
    end else begin
      dm_hi_r <= rd_sel_s ? 2'b11 : 2'b00;
      dm_lo_r <= 2'b00;
      busy_r  <= (state_s != IDLE);
    end
  end

  psram_resp_mem #(
    .BIT_WIDTH(BIT_WIDTH),
    .MEM_AW   (MEM_AW)
  ) u_mem (
    .clk    (ram_clk),
    .rst    (ram_rst),
    .wr_en  (wr_en_s),
    .wr_addr(ptr_r),
    .wr_hi  (dq_out_hi),
    .wr_lo  (dq_out_lo),
    .be_hi  (~dm_out_hi),
    .be_lo  (~dm_out_lo),
    .rd_en  (mem_rd_s),
    .rd_addr(ptr_r),
    .ld_en  (mr_ld_s),
    .ld_word(BIT_WIDTH'(mr_r[mr_idx_r])),
    .q_hi   (dq_in_hi),
    .q_lo   (dq_in_lo)
  );

  assign dm_in_hi  = dm_hi_r;
  assign dm_in_lo  = dm_lo_r;
  assign resp_busy = busy_r;
  assign unused_s  = ^{dq_en, dm_en, addr_full_s};

`ifdef PSRAM_RESP_CHECK_EN
  logic err_r;
  logic err_set_s;

  // Protocol violations seen while CE is low.
  always_comb begin
    err_set_s = 1'b0;
    if (!psram_ce) begin
      case (state_r)
        IDLE:    err_set_s = !dq_en || !cmd_known(dq_out_hi[7:0]);
        ADDR_H:  err_set_s = !dq_en;
        ADDR_L:  err_set_s = !dq_en || (((cmd_r == CMD_SYNC_WR) || (cmd_r == CMD_SYNC_RD))
                                        && dq_out_lo[0]);
        RDATA:   err_set_s = dm_en || dq_en;
        default: err_set_s = 1'b0;
      endcase
    end else begin
      err_set_s = 1'b0;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge ram_clk) begin
    if (ram_rst) err_r <= 1'b0;
    else err_r <= err_r | err_set_s;
  end

  assign err_protocol = err_r;
`else
  assign err_protocol = 1'b0;
`endif

endmodule

// File: tb/tb_psram_responder.sv
// Directed self-checking bench for psram_responder (LATENCY=3, 16-bit, wrap at 32).
// Expected error-flag behaviour follows PSRAM_RESP_CHECK_EN.
module tb_psram_responder;

`ifdef PSRAM_RESP_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        ram_clk = 1'b0;
  logic        ram_rst;
  logic        psram_ce;
  logic        dq_en;
  logic [15:0] dq_out_hi;
  logic [15:0] dq_out_lo;
  logic        dm_en;
  logic [1:0]  dm_out_hi;
  logic [1:0]  dm_out_lo;
  logic [15:0] dq_in_hi;
  logic [15:0] dq_in_lo;
  logic [1:0]  dm_in_hi;
  logic [1:0]  dm_in_lo;
  logic        resp_busy;
  logic        err_protocol;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] wbuf [0:15];
  logic [15:0] ebuf [0:15];
  logic [1:0]  wmask_hi = 2'b00;
  logic [1:0]  wmask_lo = 2'b00;

  always #5 ram_clk = ~ram_clk;

  psram_responder #(
    .LATENCY  (3),
    .BIT_WIDTH(16),
    .BURST_LEN(32),
    .WARP_MODE("Wrap"),
    .MEM_AW   (10)
  ) dut (
    .ram_clk     (ram_clk),
    .ram_rst     (ram_rst),
    .psram_ce    (psram_ce),
    .dq_en       (dq_en),
    .dq_out_hi   (dq_out_hi),
    .dq_out_lo   (dq_out_lo),
    .dm_en       (dm_en),
    .dm_out_hi   (dm_out_hi),
    .dm_out_lo   (dm_out_lo),
    .dq_in_hi    (dq_in_hi),
    .dq_in_lo    (dq_in_lo),
    .dm_in_hi    (dm_in_hi),
    .dm_in_lo    (dm_in_lo),
    .resp_busy   (resp_busy),
    .err_protocol(err_protocol)
  );

  task automatic cyc();
    @(posedge ram_clk);
    #1;
  endtask

  task automatic idle_in();
    psram_ce  = 1'b1;
    dq_en     = 1'b0;
    dm_en     = 1'b0;
    dq_out_hi = 16'h0000;
    dq_out_lo = 16'h0000;
    dm_out_hi = 2'b00;
    dm_out_lo = 2'b00;
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [31:0] addr);
    psram_ce  = 1'b0;
    dq_en     = 1'b1;
    dq_out_hi = {8'h00, cmd};
    dq_out_lo = 16'h0000;
    cyc();
    dq_out_hi = {8'h00, addr[31:24]};
    dq_out_lo = {8'h00, addr[23:16]};
    cyc();
    dq_out_hi = {8'h00, addr[15:8]};
    dq_out_lo = {8'h00, addr[7:0]};
    cyc();
  endtask

  task automatic wr_burst(input logic [31:0] addr, input int n);
    send_hdr(8'h20, addr);
    repeat (3) cyc();
    dm_en = 1'b1;
    for (int k = 0; k < n; k++) begin
      dq_out_hi = wbuf[2*k];
      dq_out_lo = wbuf[2*k+1];
      dm_out_hi = wmask_hi;
      dm_out_lo = wmask_lo;
      cyc();
    end
    idle_in();
    dq_out_hi = 16'hDEAD;
    dq_out_lo = 16'hDEAD;
    cyc();
  endtask

  // Reads n cycles from addr, checking latency zeros, data/strobe, then the CE-rise cleanup.
  task automatic rd_check(input string name, input logic [31:0] addr, input int n);
    logic [36:0] obs, want;
    send_hdr(8'hA0, addr);
    dq_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      obs  = {resp_busy, dq_in_hi, dq_in_lo, dm_in_hi, dm_in_lo};
      want = {1'b1, 36'h0};
      n_cmp++;
      if (obs !== want) begin
        n_bad++;
        $display("FAIL %s_lat%0d: got %h want %h", name, k, obs, want);
      end
      cyc();
    end
    for (int k = 0; k < n; k++) begin
      obs  = {resp_busy, dq_in_hi, dq_in_lo, dm_in_hi, dm_in_lo};
      want = {1'b1, ebuf[2*k], ebuf[2*k+1], 2'b11, 2'b00};
      n_cmp++;
      if (obs !== want) begin
        n_bad++;
        $display("FAIL %s_data%0d: got %h want %h", name, k, obs, want);
      end
      if (k == n - 1) idle_in();
      cyc();
    end
    obs  = {resp_busy, dq_in_hi, dq_in_lo, dm_in_hi, dm_in_lo};
    want = 37'h0;
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s_end: got %h want %h", name, obs, want);
    end
  endtask

  task automatic mr_write(input logic [2:0] idx, input logic [7:0] val);
    send_hdr(8'hC0, {29'h0, idx});
    dq_out_hi = {8'h00, val};
    cyc();
    idle_in();
    cyc();
  endtask

  task automatic mr_read_check(input string name, input logic [2:0] idx, input logic [7:0] val);
    logic [36:0] obs, want;
    send_hdr(8'h40, {29'h0, idx});
    dq_en = 1'b0;
    repeat (3) cyc();
    obs  = {resp_busy, dq_in_hi, dq_in_lo, dm_in_hi, dm_in_lo};
    want = {1'b1, 8'h00, val, 8'h00, val, 2'b11, 2'b00};
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s_data: got %h want %h", name, obs, want);
    end
    cyc();
    obs  = {resp_busy, dq_in_hi, dq_in_lo, dm_in_hi, dm_in_lo};
    want = {1'b1, 36'h0};
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s_ignore: got %h want %h", name, obs, want);
    end
    idle_in();
    cyc();
    obs  = {resp_busy, dq_in_hi, dq_in_lo, dm_in_hi, dm_in_lo};
    want = 37'h0;
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s_end: got %h want %h", name, obs, want);
    end
  endtask

  task automatic test_reset();
    logic [37:0] obs;
    idle_in();
    ram_rst = 1'b1;
    repeat (3) cyc();
    ram_rst = 1'b0;
    cyc();
    obs = {resp_busy, err_protocol, dq_in_hi, dq_in_lo, dm_in_hi, dm_in_lo};
    n_cmp++;
    if (obs !== 38'h0) begin
      n_bad++;
      $display("FAIL reset_state: got %h want %h", obs, 38'h0);
    end
  endtask

  task automatic test_linear_rw();
    for (int i = 0; i < 8; i++) begin
      wbuf[i] = 16'h1111 * 16'(i + 1);
      ebuf[i] = 16'h1111 * 16'(i + 1);
    end
    wmask_hi = 2'b00;
    wmask_lo = 2'b00;
    wr_burst(32'h0000_0010, 4);
    rd_check("linear", 32'h0000_0010, 4);
  endtask

  task automatic test_wrap();
    wbuf[0] = 16'hBEEF; wbuf[1] = 16'hCAFE;
    wr_burst(32'h0000_0020, 1);
    wbuf[0] = 16'hA1A1; wbuf[1] = 16'hB2B2; wbuf[2] = 16'hC3C3; wbuf[3] = 16'hD4D4;
    wr_burst(32'h0000_001E, 2);
    ebuf[0] = 16'hA1A1; ebuf[1] = 16'hB2B2; ebuf[2] = 16'hC3C3; ebuf[3] = 16'hD4D4;
    rd_check("wrap_1e", 32'h0000_001E, 2);
    ebuf[0] = 16'hC3C3; ebuf[1] = 16'hD4D4;
    rd_check("wrap_00", 32'h0000_0000, 1);
    ebuf[0] = 16'hBEEF; ebuf[1] = 16'hCAFE;
    rd_check("wrap_20", 32'h0000_0020, 1);
  endtask

  task automatic test_masked_write();
    wbuf[0] = 16'hAAAA; wbuf[1] = 16'hAAAA;
    wr_burst(32'h0000_0040, 1);
    wbuf[0] = 16'h5555; wbuf[1] = 16'h5555;
    wmask_hi = 2'b01;
    wr_burst(32'h0000_0040, 1);
    wmask_hi = 2'b00;
    ebuf[0] = 16'h55AA; ebuf[1] = 16'h5555;
    rd_check("mask_hi", 32'h0000_0040, 1);
    wbuf[0] = 16'hAAAA; wbuf[1] = 16'hAAAA;
    wr_burst(32'h0000_0042, 1);
    wbuf[0] = 16'h5555; wbuf[1] = 16'h5555;
    wmask_lo = 2'b10;
    wr_burst(32'h0000_0042, 1);
    wmask_lo = 2'b00;
    ebuf[0] = 16'h5555; ebuf[1] = 16'hAA55;
    rd_check("mask_lo", 32'h0000_0042, 1);
  endtask

  task automatic test_mode_reg();
    mr_write(3'd2, 8'h3C);
    mr_read_check("mr2", 3'd2, 8'h3C);
    mr_write(3'd5, 8'h81);
    mr_read_check("mr5", 3'd5, 8'h81);
    mr_read_check("mr2_keep", 3'd2, 8'h3C);
    mr_read_check("mr7_zero", 3'd7, 8'h00);
  endtask

  task automatic test_abort_lat();
    send_hdr(8'h20, 32'h0000_0010);
    dq_out_hi = 16'hDEAD;
    dq_out_lo = 16'hDEAD;
    psram_ce  = 1'b1;
    cyc();
    n_cmp++;
    if (resp_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_busy: got %b want %b", resp_busy, 1'b0);
    end
    repeat (4) cyc();
    idle_in();
    ebuf[0] = 16'h1111; ebuf[1] = 16'h2222; ebuf[2] = 16'h3333; ebuf[3] = 16'h4444;
    rd_check("abort_mem", 32'h0000_0010, 2);
  endtask

  task automatic test_reset_mid_read();
    logic [36:0] obs, want;
    send_hdr(8'hA0, 32'h0000_0010);
    dq_en = 1'b0;
    repeat (3) cyc();
    obs  = {resp_busy, dq_in_hi, dq_in_lo, dm_in_hi, dm_in_lo};
    want = {1'b1, 16'h1111, 16'h2222, 2'b11, 2'b00};
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL rstrd_data: got %h want %h", obs, want);
    end
    ram_rst = 1'b1;
    cyc();
    obs = {resp_busy, dq_in_hi, dq_in_lo, dm_in_hi, dm_in_lo};
    n_cmp++;
    if (obs !== 37'h0) begin
      n_bad++;
      $display("FAIL rstrd_zero: got %h want %h", obs, 37'h0);
    end
    ram_rst = 1'b0;
    idle_in();
    cyc();
    ebuf[0] = 16'h1111; ebuf[1] = 16'h2222; ebuf[2] = 16'h3333; ebuf[3] = 16'h4444;
    rd_check("rstrd_again", 32'h0000_0010, 2);
    mr_read_check("rstrd_mr2", 3'd2, 8'h00);
  endtask

  task automatic test_bad_cmd();
    logic [1:0] obs;
    psram_ce  = 1'b0;
    dq_en     = 1'b1;
    dq_out_hi = 16'h0077;
    cyc();
    obs = {resp_busy, err_protocol};
    n_cmp++;
    if (obs !== {1'b1, EXP_ERR}) begin
      n_bad++;
      $display("FAIL badcmd_set: got %b want %b", obs, {1'b1, EXP_ERR});
    end
    dq_out_hi = 16'h00C0;
    repeat (2) cyc();
    idle_in();
    repeat (2) cyc();
    obs = {resp_busy, err_protocol};
    n_cmp++;
    if (obs !== {1'b0, EXP_ERR}) begin
      n_bad++;
      $display("FAIL badcmd_sticky: got %b want %b", obs, {1'b0, EXP_ERR});
    end
    mr_read_check("badcmd_mr0", 3'd0, 8'h00);
    ram_rst = 1'b1;
    cyc();
    ram_rst = 1'b0;
    cyc();
    n_cmp++;
    if (err_protocol !== 1'b0) begin
      n_bad++;
      $display("FAIL badcmd_clear: got %b want %b", err_protocol, 1'b0);
    end
  endtask

  initial begin
    ram_rst = 1'b1;
    test_reset();
    test_linear_rw();
    test_wrap();
    test_masked_write();
    test_mode_reg();
    test_abort_lat();
    test_reset_mid_read();
    test_bad_cmd();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
